// File: rtl/seq_divider_pkg.sv
// ============================================================================
// Module : seq_divider_pkg
// Brief  : Op codes and op-decode helpers shared by the sequential divider.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package seq_divider_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    function automatic logic op_is_signed(input logic [1:0] i_op);
        return ~i_op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] i_op);
        return i_op[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider_div_step.sv
// ============================================================================
// Module : seq_divider_div_step
// Brief  : One combinational radix-2 restoring division iteration.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_divider_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    // The shifted remainder keeps its carry bit so divisors above 2^(XLEN-1) still work.
    logic [XLEN:0]   w_shift;
    logic            w_fits;
    logic [XLEN-1:0] w_diff;

    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_fits  = (w_shift >= {1'b0, i_div});
    assign w_diff  = w_shift[XLEN-1:0] - i_div;

    assign o_rem = w_fits ? w_diff : w_shift[XLEN-1:0];
    assign o_quo = {i_quo[XLEN-2:0], w_fits};

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module : seq_divider
// Brief  : 34-cycle restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] r
);

    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [XLEN-1:0] c_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   c_LAST    = CW'(XLEN - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic            r_is_rem;
    logic            r_qneg;
    logic            r_rneg;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_result;

    logic            w_accept;
    logic            w_signed;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;

    assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_signed  = op_is_signed(op);
    assign w_b_zero  = (b == '0);
    assign w_ovf     = w_signed && (a == c_MIN_NEG) && (b == '1);
    assign w_special = w_b_zero || w_ovf;
    assign w_abs_a   = (w_signed && a[XLEN-1]) ? -a : a;
    assign w_abs_b   = (w_signed && b[XLEN-1]) ? -b : b;

    seq_divider_div_step #(
        .XLEN (XLEN)
    ) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next_state = w_special ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (r_count == c_LAST) w_next_state = S_FIX;
            end
            S_FIX: begin
                w_next_state = S_DONE;
            end
            default: begin
                if (w_accept) w_next_state = w_special ? S_DONE : S_CALC;
                else          w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (r_state == S_CALC) || (r_state == S_FIX);
        done = (r_state == S_DONE);
        r    = r_result;
    end

    // Operand latching, iteration and sign fix-up; the result only moves on
    // a special-case accept or in FIX, so it holds through IDLE and DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_rem <= 1'b0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_count  <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_is_rem <= op_is_rem(op);
            r_qneg   <= w_signed && (a[XLEN-1] ^ b[XLEN-1]);
            r_rneg   <= w_signed && a[XLEN-1];
            r_rem    <= '0;
            r_quo    <= w_abs_a;
            r_div    <= w_abs_b;
            r_count  <= '0;
            if (w_b_zero) begin
                r_result <= op_is_rem(op) ? a : '1;
            end else if (w_ovf) begin
                r_result <= op_is_rem(op) ? '0 : c_MIN_NEG;
            end
        end else if (r_state == S_CALC) begin
            r_rem   <= w_rem_nxt;
            r_quo   <= w_quo_nxt;
            r_count <= r_count + 1'b1;
        end else if (r_state == S_FIX) begin
            if (r_is_rem) r_result <= r_rneg ? -r_rem : r_rem;
            else          r_result <= r_qneg ? -r_quo : r_quo;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module : tb_seq_divider
// Brief  : Directed and random checks of seq_divider against an arithmetic model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_seq_divider;
    import seq_divider_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] r;

    int vectors     = 0;
    int miscompares = 0;

    seq_divider #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .r     (r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RISC-V M semantics via 64-bit signed arithmetic; truncation gives overflow results.
    function automatic logic [31:0] ref_result(input logic [1:0] f_op, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        if (y == 32'd0) return (f_op == DIV_OP_REM || f_op == DIV_OP_REMU) ? x : 32'hFFFF_FFFF;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (f_op)
            DIV_OP_DIVU: return x / y;
            DIV_OP_REMU: return x % y;
            DIV_OP_DIV:  begin q = sx / sy; return q[31:0]; end
            default:     begin q = sx % sy; return q[31:0]; end
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] f_op, input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return 1;
        if ((f_op == DIV_OP_DIV || f_op == DIV_OP_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic run_op(input logic [1:0] f_op, input logic [31:0] x, input logic [31:0] y,
                          input int pulse_cyc, input bit chain);
        int          cyc;
        int          lat;
        bit          saw_busy;
        logic [31:0] exp_r;
        lat   = ref_latency(f_op, x, y);
        exp_r = ref_result(f_op, x, y);
        op = f_op; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        cyc = 1;
        saw_busy = 1'b0;
        while (!done && cyc < 40) begin
            if (busy) saw_busy = 1'b1;
            start = (cyc == pulse_cyc);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check($sformatf("latency op%0d %h/%h", f_op, x, y), 32'(cyc), 32'(lat));
        check($sformatf("busy_seen op%0d %h/%h", f_op, x, y), {31'd0, saw_busy}, {31'd0, lat != 1});
        check($sformatf("result op%0d %h/%h", f_op, x, y), r, exp_r);
        if (!chain) begin
            @(posedge clk); #1;
            check("done_one_cycle", {31'd0, done}, 32'd0);
            check("result_held", r, exp_r);
        end
    endtask

    initial begin
        int          dones;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_r", r, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(DIV_OP_DIVU, 32'd100, 32'd7, 0, 1'b0);
        run_op(DIV_OP_REMU, 32'd100, 32'd7, 0, 1'b0);
        run_op(DIV_OP_DIV,  32'hFFFF_FFEC, 32'd3, 0, 1'b0);
        run_op(DIV_OP_REM,  32'hFFFF_FFEC, 32'd3, 0, 1'b0);
        run_op(DIV_OP_DIV,  32'h1234_5678, 32'd0, 0, 1'b0);
        run_op(DIV_OP_DIVU, 32'h1234_5678, 32'd0, 0, 1'b0);
        run_op(DIV_OP_REM,  32'h1234_5678, 32'd0, 0, 1'b0);
        run_op(DIV_OP_REMU, 32'h1234_5678, 32'd0, 0, 1'b0);
        run_op(DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 0, 1'b0);

        // A stray start mid-operation is ignored, then a back-to-back start in DONE.
        run_op(DIV_OP_DIVU, 32'd50, 32'd5, 10, 1'b1);
        run_op(DIV_OP_REMU, 32'd50, 32'd7, 0, 1'b0);

        // Reset partway through a divide.
        op = DIV_OP_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (13) begin @(posedge clk); #1; end
        check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_r", r, 32'd0);
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("no_done_after_rst", 32'(dones), 32'd0);
        run_op(DIV_OP_DIVU, 32'd9, 32'd3, 0, 1'b0);

        // Reset and start on the same edge: reset wins.
        op = DIV_OP_DIVU; a = 32'd9; b = 32'd0; start = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        check("rst_beats_start_done", {31'd0, done}, 32'd0);
        check("rst_beats_start_r", r, 32'd0);

        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = -32'($urandom_range(1, 15));
                3:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, 0, 1'($urandom_range(0, 1)));
        end
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
